fifod2mac: RTL and testbench
============================

Name: fifod2mac

Overview:
- Downstream stage of the command sequencer's ETH_SEND state: when `fs_fifod2mac` is raised, it drains one ADC frame from FIFO D and streams it byte-wise to the UDP/MAC transmit interface.
- Each frame is framed as: sync header, frame counter, 16-bit payload length, payload, optional checksum.
- It reports completion on `fd_fifod2mac`.
- The sequencer holds `fs_fifod2mac` high until it sees `fd_fifod2mac`.

Parameters:
- BYTES_PER_ADC, 64: payload bytes contributed per ADC sample set; payload length = adc_cnt * BYTES_PER_ADC.
- SYNC0, 8'h55: first header byte.
- SYNC1, 8'hAA: second header byte.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fs_fifod2mac  in  1  start level from sequencer, held until fd seen.
- fd_fifod2mac  out  1  frame done; held until fs_fifod2mac falls.
- adc_cnt  in  8  number of ADC sets in this frame; sampled at frame start.
- fifod_dout  in  8  FIFO D data, first-word-fall-through (valid while !fifod_empty).
- fifod_empty  in  1  FIFO D empty.
- fifod_rd_en  out  1  pop FIFO D.
- udp_txd  out  8  transmit byte.
- udp_tx_valid  out  1  udp_txd valid.
- udp_tx_ready  in  1  MAC accepts the byte when valid&ready.
- udp_tx_last  out  1  marks the final byte of the frame.
- frame_num  out  8  current frame counter (debug).

Behaviour:
- **Reset** (rst_n low, async):
  - state=IDLE.
  - All outputs 0; frame_num=0.
  - Byte counter=0, length register=0, checksum=0.
  - Reset mid-frame aborts the frame with no further bytes; the FIFO is not flushed by this block.
- **Handshake:**
  - A frame starts on the rising edge of fs_fifod2mac, detected via a registered copy; a level held high after LAST does not retrigger.
  - fs falling mid-frame is ignored and the frame completes.
- **IDLE:** on fs rising edge -> LOAD.
- **LOAD** (1 cycle):
  - len = adc_cnt * BYTES_PER_ADC, 16-bit, truncated to 16 bits.
  - Clear byte counter and checksum -> HEAD.
- **HEAD:**
  - udp_tx_valid=1; bytes in order: SYNC0, SYNC1, frame_num, len[15:8], len[7:0].
  - Advance only on valid&ready.
  - After byte 4 is accepted -> PAYL, or -> CSUM/LAST if len==0.
- **PAYL:**
  - udp_txd=fifod_dout; udp_tx_valid = !fifod_empty.
  - fifod_rd_en = udp_tx_ready & !fifod_empty (combinational; exactly one pop per accepted byte).
  - FIFO empty stalls with valid=0; no timeout, no underflow pop.
  - After len bytes are accepted -> CSUM (macro defined) or LAST.
- **udp_tx_last:** asserted with the final byte of the frame (last payload byte, last header byte if len==0, or checksum byte).
- **LAST:**
  - fd_fifod2mac=1; frame_num increments by 1 on entry (wraps 8'hFF->8'h00).
  - Remain until fs_fifod2mac==0, then -> IDLE with fd=0.
- **Backpressure:** udp_txd and udp_tx_valid must hold stable while valid & !ready.
- **Checksum:** XOR of all header and payload bytes accepted so far, updated on each handshake.
- **Throughput:** 1 byte per cycle when ready stays high and the FIFO is non-empty.
- **Latency:** first header byte valid 2 cycles after the fs rising edge (edge detect + LOAD).

Optional Feature:
- FIFOD2MAC_CSUM_EN defined:
  - State CSUM follows PAYL (or HEAD if len==0) and sends one byte = running XOR checksum, with udp_tx_last=1.
  - It then goes to LAST.
- Not defined:
  - No CSUM state and no checksum register.
  - Frame ends after the payload.
  - udp_tx_last sits on the last payload byte, or on len[7:0] when len==0.

Test Plan:
- adc_cnt=1, BYTES_PER_ADC=64, FIFO preloaded with 0..63, ready=1:
  - bytes 55 AA 00 00 40 then 00..3F in 69 consecutive cycles.
  - last on 3F (CSUM_EN: extra byte = XOR of all, last on it).
  - fd high, frame_num=1.
- Same frame with ready toggling 1/0 each cycle: identical byte sequence; udp_txd stable during stalls; exactly 64 pops.
- FIFO holds 10 bytes, 54 arrive after 20 empty cycles: valid=0 and rd_en=0 while empty; frame completes correctly.
- adc_cnt=0: header 55 AA nn 00 00 only; last on 5th byte (or on the checksum byte); no FIFO reads.
- 256 back-to-back frames: frame_num byte wraps FF->00; fd drops one cycle after fs falls each time; no retrigger while fs stays high.
- rst_n low during PAYL: all outputs 0 immediately; next fs edge starts a fresh frame with header byte 0 = 55.

Source files
------------

// File: rtl/fifod2mac_if.sv
// Handshake, FIFO D and UDP/MAC transmit signals of the fifod2mac stage.
// slave = the fifod2mac block, master = whatever drives it (sequencer, FIFO, MAC).
interface fifod2mac_if;
    logic       fs_fifod2mac;
    logic       fd_fifod2mac;
    logic [7:0] adc_cnt;
    logic [7:0] fifod_dout;
    logic       fifod_empty;
    logic       fifod_rd_en;
    logic [7:0] udp_txd;
    logic       udp_tx_valid;
    logic       udp_tx_ready;
    logic       udp_tx_last;
    logic [7:0] frame_num;

    modport slave (
        input  fs_fifod2mac, adc_cnt, fifod_dout, fifod_empty, udp_tx_ready,
        output fd_fifod2mac, fifod_rd_en, udp_txd, udp_tx_valid, udp_tx_last, frame_num
    );

    modport master (
        output fs_fifod2mac, adc_cnt, fifod_dout, fifod_empty, udp_tx_ready,
        input  fd_fifod2mac, fifod_rd_en, udp_txd, udp_tx_valid, udp_tx_last, frame_num
    );
endinterface

// File: rtl/fifod2mac.sv
// Drains one ADC frame from FWFT FIFO D to the UDP/MAC tx port (sync, frame#, len, payload); FIFOD2MAC_CSUM_EN adds an XOR byte.
// First byte valid 2 cycles after fs rises, then 1 byte/cycle; txd/valid hold while valid & !ready, FIFO empty stalls.
module fifod2mac #(
    parameter int         BYTES_PER_ADC = 64,
    parameter logic [7:0] SYNC0         = 8'h55,
    parameter logic [7:0] SYNC1         = 8'hAA
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    fifod2mac_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEAD,
        S_PAYL,
`ifdef FIFOD2MAC_CSUM_EN
        S_CSUM,
`endif
        S_LAST
    } state_t;

`ifdef FIFOD2MAC_CSUM_EN
    localparam state_t S_DONE = S_CSUM;
`else
    localparam state_t S_DONE = S_LAST;
`endif

    state_t      state_q, state_d;
    logic        fs_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  frame_num_q, frame_num_d;
`ifdef FIFOD2MAC_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic [7:0]  txd;
    logic        tx_vld;
    logic        tx_last;
    logic        rd_en;
    logic        fd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        frame_num_d = frame_num_q;
`ifdef FIFOD2MAC_CSUM_EN
        csum_d      = csum_q;
`endif
        txd         = 8'h00;
        tx_vld      = 1'b0;
        tx_last     = 1'b0;
        rd_en       = 1'b0;
        fd          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.fs_fifod2mac && !fs_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                len_d   = 16'(32'(bus.adc_cnt) * BYTES_PER_ADC);
                cnt_d   = 16'd0;
`ifdef FIFOD2MAC_CSUM_EN
                csum_d  = 8'h00;
`endif
                state_d = S_HEAD;
            end
            S_HEAD: begin
                tx_vld = 1'b1;
                case (cnt_q[2:0])
                    3'd0:    txd = SYNC0;
                    3'd1:    txd = SYNC1;
                    3'd2:    txd = frame_num_q;
                    3'd3:    txd = len_q[15:8];
                    default: txd = len_q[7:0];
                endcase
`ifndef FIFOD2MAC_CSUM_EN
                tx_last = (cnt_q == 16'd4) && (len_q == 16'd0);
`endif
                if (bus.udp_tx_ready) begin
                    if (cnt_q == 16'd4) begin
                        cnt_d   = 16'd0;
                        state_d = (len_q == 16'd0) ? S_DONE : S_PAYL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_PAYL: begin
                // FWFT: the head word is presented directly and popped only on acceptance
                txd    = bus.fifod_dout;
                tx_vld = !bus.fifod_empty;
                rd_en  = bus.udp_tx_ready && !bus.fifod_empty;
`ifndef FIFOD2MAC_CSUM_EN
                tx_last = tx_vld && (cnt_q == len_q - 16'd1);
`endif
                if (rd_en) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == len_q - 16'd1) state_d = S_DONE;
                end
            end
`ifdef FIFOD2MAC_CSUM_EN
            S_CSUM: begin
                txd     = csum_q;
                tx_vld  = 1'b1;
                tx_last = 1'b1;
                if (bus.udp_tx_ready) state_d = S_LAST;
            end
`endif
            S_LAST: begin
                fd = 1'b1;
                if (!bus.fs_fifod2mac) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_LAST && state_q != S_LAST) frame_num_d = frame_num_q + 8'd1;
`ifdef FIFOD2MAC_CSUM_EN
        if (tx_vld && bus.udp_tx_ready && state_q != S_CSUM) csum_d = csum_q ^ txd;
`endif
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fs_q        <= 1'b0;
            cnt_q       <= 16'd0;
            len_q       <= 16'd0;
            frame_num_q <= 8'd0;
`ifdef FIFOD2MAC_CSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            fs_q        <= bus.fs_fifod2mac;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            frame_num_q <= frame_num_d;
`ifdef FIFOD2MAC_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.udp_txd      = txd;
    assign bus.udp_tx_valid = tx_vld;
    assign bus.udp_tx_last  = tx_last;
    assign bus.fifod_rd_en  = rd_en;
    assign bus.fd_fifod2mac = fd;
    assign bus.frame_num    = frame_num_q;
endmodule

// File: tb/tb_fifod2mac.sv
// Randomized bench for fifod2mac: FWFT FIFO and MAC models drive the DUT, a frame-level reference checks every cycle.
`timescale 1ns/1ps
module tb_fifod2mac;
    logic sys_clk = 1'b0;
    logic rst_n;
    always #5 sys_clk = ~sys_clk;

    fifod2mac_if bus();
    fifod2mac dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));

`ifdef FIFOD2MAC_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO / MAC environment
    logic [7:0] fifo[$];
    logic [7:0] arr_q[$];
    logic [7:0] ref_q[$];
    int         hold     = 0;
    int         rdy_mode = 0;
    logic       pop_s    = 1'b0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    bit         active, fd_exp, fs_prev, prev_stall;
    logic [7:0] fn_exp, prev_txd;
    int         lat, acc_n, len_m, pop_cnt, last_pops;
    int         cyc = 0, first_cyc, last_cyc;

    task automatic drive_fifo();
        bus.fifod_empty = (fifo.size() == 0);
        bus.fifod_dout  = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (pop_s && fifo.size() > 0) void'(fifo.pop_front());
        if (hold > 0) hold--;
        else while (arr_q.size() > 0) fifo.push_back(arr_q.pop_front());
        case (rdy_mode)
            0:       bus.udp_tx_ready = 1'b1;
            1:       bus.udp_tx_ready = !bus.udp_tx_ready;
            default: bus.udp_tx_ready = 1'($urandom_range(0, 1));
        endcase
        drive_fifo();
    endtask

    task automatic load_frame(input int ac, input int preload, input int delay, input bit inc);
        logic [7:0] b;
        for (int i = 0; i < ac * 64; i++) begin
            b = inc ? 8'(i) : 8'($urandom);
            ref_q.push_back(b);
            if (i < preload) fifo.push_back(b);
            else arr_q.push_back(b);
        end
        hold        = delay;
        bus.adc_cnt = 8'(ac);
        drive_fifo();
    endtask

    task automatic end_frame(input int drop_at, input int budget, input int hold_hi);
        int n = 0;
        while (!bus.fd_fifod2mac && n < budget) begin
            if (n == drop_at) bus.fs_fifod2mac = 1'b0;
            tick();
            n++;
        end
        chk("fd_seen", bus.fd_fifod2mac, 1);
        for (int i = 0; i < hold_hi; i++) begin
            tick();
            chk("fd_held", {bus.fd_fifod2mac, bus.udp_tx_valid}, 2'b10);
        end
        bus.fs_fifod2mac = 1'b0;
        tick();
        chk("fd_drop", bus.fd_fifod2mac, 0);
    endtask

    // Compare process: outputs sampled on the falling edge, model advanced per accepted byte
    initial begin
        forever begin
            logic       vld, rdy, rd, lst, ev, hdr, pay, fd_nx;
            logic [7:0] txd, x;
            logic [15:0] len16;
            @(negedge sys_clk);
            cyc++;
            vld = bus.udp_tx_valid;
            rdy = bus.udp_tx_ready;
            rd  = bus.fifod_rd_en;
            lst = bus.udp_tx_last;
            txd = bus.udp_txd;
            if (!rst_n) begin
                chk("rst_outs", {vld, rd, lst, bus.fd_fifod2mac, bus.frame_num, txd}, 0);
                active = 0; fd_exp = 0; fs_prev = 0; lat = 0; acc_n = 0;
                fn_exp = 8'd0; prev_stall = 0; pop_s = 1'b0;
                exp_q.delete();
            end else begin
                pop_s = rd;
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        len_m = int'(bus.adc_cnt) * 64;
                        len16 = 16'(len_m);
                        exp_q = {8'h55, 8'hAA, fn_exp, len16[15:8], len16[7:0]};
                        for (int i = 0; i < len_m; i++)
                            exp_q.push_back(ref_q.size() > 0 ? ref_q.pop_front() : 8'h00);
                        if (CS != 0) begin
                            x = 8'h00;
                            foreach (exp_q[i]) x ^= exp_q[i];
                            exp_q.push_back(x);
                        end
                        active = 1; acc_n = 0; pop_cnt = 0; first_cyc = -1;
                        log_q.delete();
                    end
                end else if (!active && !fd_exp && bus.fs_fifod2mac && !fs_prev) begin
                    lat = 2;
                end

                chk("fd", bus.fd_fifod2mac, fd_exp);
                chk("frame_num", bus.frame_num, fn_exp);
                fd_nx = fd_exp && bus.fs_fifod2mac;

                if (active) begin
                    hdr = (acc_n < 5);
                    pay = (acc_n >= 5) && (acc_n < 5 + len_m);
                    ev  = pay ? !bus.fifod_empty : 1'b1;
                    chk("valid", vld, ev);
                    chk("rd_en", rd, pay && !bus.fifod_empty && rdy);
                    if (prev_stall) chk("stall_hold", {vld, txd}, {1'b1, prev_txd});
                    if (vld) begin
                        chk("txd", txd, exp_q[0]);
                        chk("last", lst, exp_q.size() == 1);
                    end
                    if (rd) pop_cnt++;
                    prev_stall = vld && !rdy;
                    prev_txd   = txd;
                    if (vld && rdy) begin
                        if (first_cyc < 0) first_cyc = cyc;
                        last_cyc = cyc;
                        log_q.push_back(txd);
                        void'(exp_q.pop_front());
                        acc_n++;
                        if (exp_q.size() == 0) begin
                            active    = 0;
                            fd_nx     = 1;
                            fn_exp    = fn_exp + 8'd1;
                            last_pops = pop_cnt;
                        end
                    end
                    if (hdr && !vld) prev_stall = 0;
                end else begin
                    chk("idle_valid", vld, 0);
                    chk("idle_rd_en", rd, 0);
                    prev_stall = 0;
                end
                fd_exp  = fd_nx;
                fs_prev = bus.fs_fifod2mac;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b1;
        bus.fs_fifod2mac = 1'b0;
        bus.adc_cnt      = 8'd0;
        bus.udp_tx_ready = 1'b0;
        drive_fifo();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: one ADC set, payload 0..63, ready always high
        rdy_mode = 0;
        bus.udp_tx_ready = 1'b1;
        load_frame(1, 64, 0, 1);
        bus.fs_fifod2mac = 1'b1;
        tick();
        chk("lat_load_valid", bus.udp_tx_valid, 0);
        tick();
        chk("lat_head_valid", bus.udp_tx_valid, 1);
        chk("lat_head_byte", bus.udp_txd, 8'h55);
        end_frame(-1, 500, 0);
        chk("t1_count", log_q.size(), 69 + CS);
        chk("t1_span", last_cyc - first_cyc + 1, 69 + CS);
        if (log_q.size() >= 69) begin
            chk("t1_b0", log_q[0], 8'h55);
            chk("t1_b1", log_q[1], 8'hAA);
            chk("t1_b2", log_q[2], 8'h00);
            chk("t1_b3", log_q[3], 8'h00);
            chk("t1_b4", log_q[4], 8'h40);
            chk("t1_b5", log_q[5], 8'h00);
            chk("t1_b68", log_q[68], 8'h3F);
        end
        if (CS != 0 && log_q.size() == 70) chk("t1_csum", log_q[69], 8'hBF);
        chk("t1_frame_num", bus.frame_num, 8'd1);
        chk("t1_pops", last_pops, 64);

        // 2: same frame with ready toggling every cycle
        rdy_mode = 1;
        load_frame(1, 64, 0, 1);
        bus.fs_fifod2mac = 1'b1;
        end_frame(-1, 500, 0);
        chk("t2_count", log_q.size(), 69 + CS);
        chk("t2_pops", last_pops, 64);

        // 3: 10 bytes ready, 54 after a long empty stretch; fs dropped mid-frame
        rdy_mode = 0;
        load_frame(1, 10, 40, 0);
        bus.fs_fifod2mac = 1'b1;
        end_frame(20, 500, 0);
        chk("t3_count", log_q.size(), 69 + CS);
        chk("t3_pops", last_pops, 64);

        // 4: empty frame
        rdy_mode = 2;
        load_frame(0, 0, 0, 0);
        bus.fs_fifod2mac = 1'b1;
        end_frame(-1, 100, 0);
        chk("t4_count", log_q.size(), 5 + CS);
        chk("t4_pops", last_pops, 0);
        if (log_q.size() >= 5) chk("t4_len_lo", log_q[4], 8'h00);

        // 5: reset in the middle of the payload
        load_frame(2, 128, 0, 0);
        bus.fs_fifod2mac = 1'b1;
        n = 0;
        while (acc_n < 20 && n < 1000) begin tick(); n++; end
        chk("t5_in_payload", acc_n >= 20, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {bus.udp_tx_valid, bus.fifod_rd_en, bus.udp_tx_last,
                            bus.fd_fifod2mac, bus.frame_num, bus.udp_txd}, 0);
        bus.fs_fifod2mac = 1'b0;
        tick();
        fifo.delete(); arr_q.delete(); ref_q.delete();
        drive_fifo();
        tick();
        rst_n = 1'b1;
        tick();
        rdy_mode = 0;
        load_frame(1, 64, 0, 1);
        bus.fs_fifod2mac = 1'b1;
        end_frame(-1, 500, 0);
        if (log_q.size() >= 3) begin
            chk("t5_b0", log_q[0], 8'h55);
            chk("t5_b2", log_q[2], 8'h00);
        end
        chk("t5_frame_num", bus.frame_num, 8'd1);

        // 6: 256 back-to-back frames, frame counter wraps
        rdy_mode = 2;
        for (int f = 0; f < 256; f++) begin
            int ac;
            ac = ($urandom_range(0, 15) == 0) ? 1 : 0;
            load_frame(ac, 64 * ac, 0, 0);
            bus.fs_fifod2mac = 1'b1;
            end_frame(-1, 1000, (f % 64 == 5) ? 6 : 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("t6_frame_num", bus.frame_num, 8'd1);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
